// File: rtl/pixel_prefetch.sv
// Raster-order pixel prefetcher: issues (x, y) to a pipelined shader ahead of the
// encoder and buffers the returned colours in a small FIFO drained by i_rd.
module pixel_prefetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LAT      = 2,
  parameter int DEPTH    = 16
) (
  input  logic                     i_pixclk,
  input  logic                     i_reset_n,
  input  logic                     i_rd,
  input  logic                     i_newline,
  input  logic                     i_newframe,
  output logic [11:0]              o_pix_x,
  output logic [10:0]              o_pix_y,
  input  logic [23:0]              i_shade,
  output logic [23:0]              o_pixel,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_underflow,
  output logic                     o_desync
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int PCW = 13;

  logic [11:0]     r_col;
  logic [10:0]     r_row;
  logic            r_frame_done;
  logic [LAT-1:0]  r_valid;
  logic [23:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [PCW-1:0]  r_pop_cnt;
  logic            r_underflow;
  logic            r_desync;

  logic            w_empty;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic [LAT-1:0]  w_valid_next;

  function automatic int count_ones(input logic [LAT-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < LAT; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  // Credit check, FIFO strobes and the next value of the in-flight shift register
  always_comb begin
    w_empty    = (r_level == LW'(0));
    w_last_col = (r_col == 12'(H_ACTIVE - 1));
    w_last_row = (r_row == 11'(V_ACTIVE - 1));
    // A same-cycle pop is deliberately ignored so credit can never overshoot DEPTH
    w_issue    = !r_frame_done && ((int'(r_level) + count_ones(r_valid)) < DEPTH);
    w_push     = r_valid[LAT-1];
    w_pop      = i_rd && !w_empty;
    w_valid_next    = '0;
    w_valid_next[0] = w_issue;
    for (int i = 1; i < LAT; i++) begin
      w_valid_next[i] = r_valid[i-1];
    end
  end

  // Raster counters, in-flight tracking and FIFO pointers; frame flush wins over all
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col        <= 12'd0;
      r_row        <= 11'd0;
      r_frame_done <= 1'b0;
      r_valid      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
    end else if (i_newframe) begin
      r_col        <= 12'd0;
      r_row        <= 11'd0;
      r_frame_done <= 1'b0;
      r_valid      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (w_issue) begin
        if (w_last_col && w_last_row) begin
          r_frame_done <= 1'b1;
        end else if (w_last_col) begin
          r_col <= 12'd0;
          r_row <= r_row + 11'd1;
        end else begin
          r_col <= r_col + 12'd1;
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 24'h0;
      end
    end else if (w_push && !i_newframe) begin
      r_mem[r_wr_ptr] <= i_shade;
    end
  end

  // Per-line pop counter and the sticky underflow / desync flags
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pop_cnt   <= '0;
      r_underflow <= 1'b0;
      r_desync    <= 1'b0;
    end else begin
      // Desync uses the count before any flush in the same cycle
      if (i_newline && (r_pop_cnt != PCW'(0)) && (r_pop_cnt != PCW'(H_ACTIVE))) begin
        r_desync <= 1'b1;
      end
      if (!i_newframe && i_rd && w_empty) begin
        r_underflow <= 1'b1;
      end
      if (i_newframe || i_newline) begin
        r_pop_cnt <= '0;
      end else if (w_pop && (r_pop_cnt != {PCW{1'b1}})) begin
        r_pop_cnt <= r_pop_cnt + PCW'(1);
      end
    end
  end

  assign o_pix_x     = r_col;
  assign o_pix_y     = 11'(V_ACTIVE - 1) - r_row;
  assign o_pixel     = w_empty ? 24'h0 : r_mem[r_rd_ptr];
  assign o_level     = r_level;
  assign o_underflow = r_underflow;
  assign o_desync    = r_desync;

endmodule
